outport_arbiter: RTL

OUTPORT_ARBITER -- requirements
Module: outport_arbiter

---
 rtl/outport_arbiter_if.sv | 23 ++
 rtl/outport_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/outport_arbiter_if.sv
// Request/grant and flit-transfer signals between the inports and one outport arbiter.
// master = the arbiter side, slave = the inport/downstream side.
interface outport_arbiter_if #(
  parameter int PORTS = 5
);
  logic [PORTS-1:0] port_rqs;
  logic             credit_in;
  logic [PORTS-1:0] arb_ack;
  logic [2:0]       xbar_sel;
  logic             xfer_en;
  logic             busy;
  logic             credit_err;

  modport master (
    input  port_rqs, credit_in,
    output arb_ack, xbar_sel, xfer_en, busy, credit_err
  );

  modport slave (
    output port_rqs, credit_in,
    input  arb_ack, xbar_sel, xfer_en, busy, credit_err
  );
endinterface

// File: rtl/outport_arbiter.sv
// Round-robin outport arbiter: grants one inport per packet, then moves its flits
// while downstream credits allow.
module outport_arbiter #(
  parameter int PORTS     = 5,
  parameter int PKT_FLITS = 4,
  parameter int BUF_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  outport_arbiter_if.master arb
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACK, XFER} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   last_q, last_d;
  logic [PW-1:0]   winner_q, winner_d;
  logic [3:0]      flit_cnt_q, flit_cnt_d;
  logic [3:0]      credits_q, credits_d;
  logic            credit_err_q, credit_err_d;
  logic            xfer_en;
  logic [PW-1:0]   pick;
  logic            found;

  // Search last+1, last+2, ... ; iterating downward lets the nearest index win.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % PORTS;
      if (arb.port_rqs[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign xfer_en = (state_q == XFER) && (credits_q != '0);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    winner_d     = winner_q;
    flit_cnt_d   = flit_cnt_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case (state_q)
      IDLE: if (found) begin
        winner_d = pick;
        state_d  = ACK;
      end
      ACK: begin
        flit_cnt_d = 4'(PKT_FLITS);
        state_d    = XFER;
      end
      XFER: if (xfer_en) begin
        flit_cnt_d = flit_cnt_q - 4'd1;
        if (flit_cnt_q == 4'd1) begin
          state_d = IDLE;
          last_d  = winner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A returned credit and a consumed one in the same cycle cancel out.
    if (xfer_en && !arb.credit_in) begin
      credits_d = credits_q - 4'd1;
    end else if (!xfer_en && arb.credit_in) begin
      if (credits_q == 4'(BUF_DEPTH)) credit_err_d = 1'b1;
      else                            credits_d    = credits_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= PW'(PORTS - 1);
      winner_q     <= '0;
      flit_cnt_q   <= '0;
      credits_q    <= 4'(BUF_DEPTH);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      winner_q     <= winner_d;
      flit_cnt_q   <= flit_cnt_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign arb.arb_ack    = (state_q == ACK) ? (PORTS'(1) << winner_q) : '0;
  assign arb.xbar_sel   = 3'(winner_q);
  assign arb.xfer_en    = xfer_en;
  assign arb.busy       = (state_q != IDLE);
  assign arb.credit_err = credit_err_q;
endmodule
